// File: rtl/pipelined_inst_decoder_pkg.sv
// pipelined_inst_decoder_pkg: default widths, the buffered decode result type
// and the first-match priority helper shared by the decoder.
package pipelined_inst_decoder_pkg;

    localparam int DEF_INST_W = 32;
    localparam int DEF_SIG_W = 4;
    localparam int DEF_IDX_W = 2;
    localparam int DEF_CNT_W = 16;
    localparam int MAX_ENTRIES = 64;

    typedef struct packed {
        logic [DEF_SIG_W-1:0] sigs;
        logic legal;
        logic [DEF_IDX_W-1:0] idx;
    } decode_result_t;

    // Lowest set bit of the hit vector wins; 0 when nothing hits.
    function automatic int first_hit(input logic [MAX_ENTRIES-1:0] hits);
        first_hit = 0;
        for (int i = MAX_ENTRIES - 1; i >= 0; i--)
            if (hits[i]) first_hit = i;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: 2-entry order-preserving valid/ready buffer; in_ready
// depends only on occupancy, never on out_ready.
module decode_skid_buf
    import pipelined_inst_decoder_pkg::*;
#(
    parameter type T = decode_result_t
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    T slot0, slot1;
    logic [1:0] cnt;
    logic push, pop;

    assign in_ready = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_data = slot0;
    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Slot 0 is always the head; a push lands in the first slot free after the pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop) slot0 <= slot1;
            if (push && (cnt - 2'(pop)) == 2'd0) slot0 <= in_data;
            if (push && (cnt - 2'(pop)) != 2'd0) slot1 <= in_data;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/pipelined_inst_decoder.sv
// pipelined_inst_decoder: mask/match first-hit decoder into a 2-entry output buffer,
// with a saturating miss counter. DECODE_BAD_CAPTURE_EN adds first-miss capture.
module pipelined_inst_decoder
    import pipelined_inst_decoder_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int SIG_W = DEF_SIG_W,
    parameter int N_ENTRIES = 4,
    parameter logic [N_ENTRIES*INST_W-1:0] TABLE_MATCH =
        {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000257B, 32'h0000277B},
    parameter logic [N_ENTRIES*INST_W-1:0] TABLE_MASK =
        {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF},
    parameter logic [N_ENTRIES*SIG_W-1:0] TABLE_SIGS = {4'h0, 4'h0, 4'h1, 4'h4},
    parameter logic [SIG_W-1:0] DEFAULT_SIGS = 4'h0,
    parameter int CNT_W = DEF_CNT_W,
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [INST_W-1:0] io_in_inst,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [SIG_W-1:0]  io_out_sigs,
    output logic              io_out_legal,
    output logic [IDX_W-1:0]  io_out_idx,
    output logic [CNT_W-1:0]  io_illegal_cnt
`ifdef DECODE_BAD_CAPTURE_EN
    ,
    output logic              io_bad_valid,
    output logic [INST_W-1:0] io_bad_inst,
    input  logic              io_bad_clr
`endif
);
    typedef struct packed {
        logic [SIG_W-1:0] sigs;
        logic legal;
        logic [IDX_W-1:0] idx;
    } result_t;

    result_t dec, head;
    logic [MAX_ENTRIES-1:0] hits;
    logic in_fire, miss;

    always_comb begin
        hits = '0;
        for (int i = 0; i < N_ENTRIES; i++)
            hits[i] = (io_in_inst & TABLE_MASK[i*INST_W +: INST_W]) == TABLE_MATCH[i*INST_W +: INST_W];
        dec.legal = |hits;
        dec.idx = IDX_W'(first_hit(hits));
        dec.sigs = dec.legal ? TABLE_SIGS[int'(dec.idx)*SIG_W +: SIG_W] : DEFAULT_SIGS;
    end

    assign in_fire = io_in_valid & io_in_ready;
    assign miss = in_fire & ~dec.legal;

    decode_skid_buf #(.T(result_t)) u_buf (
        .clk(clk),
        .reset(reset),
        .in_valid(io_in_valid),
        .in_ready(io_in_ready),
        .in_data(dec),
        .out_valid(io_out_valid),
        .out_ready(io_out_ready),
        .out_data(head)
    );

    assign io_out_sigs = head.sigs;
    assign io_out_legal = head.legal;
    assign io_out_idx = head.idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) io_illegal_cnt <= '0;
        else if (miss && io_illegal_cnt != '1) io_illegal_cnt <= io_illegal_cnt + 1'b1;
    end

`ifdef DECODE_BAD_CAPTURE_EN
    // A clear in the same cycle as a miss yields to the new capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_bad_valid <= 1'b0;
            io_bad_inst <= '0;
        end else if (miss && (!io_bad_valid || io_bad_clr)) begin
            io_bad_valid <= 1'b1;
            io_bad_inst <= io_in_inst;
        end else if (io_bad_clr) begin
            io_bad_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
// tb_pipelined_inst_decoder: directed plus random stimulus against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_pipelined_inst_decoder;
    logic clk = 0, reset = 1;
    logic in_valid = 0, out_ready = 0;
    logic [31:0] inst = 0;
    logic in_ready, out_valid, legal, in_ready2, out_valid2, legal2;
    logic [3:0] sigs, sigs2;
    logic [1:0] idx, idx2;
    logic [15:0] cnt;
    logic [1:0] cnt2;
`ifdef DECODE_BAD_CAPTURE_EN
    logic bad_valid, bad_valid2, bad_clr = 0, clr_req = 0, exp_bv = 0;
    logic [31:0] bad_inst, bad_inst2, exp_bi = 0;
`endif

    logic [6:0] q[$];
    int misses = 0, n_in = 0, dut_in = 0, dut_out = 0;
    int n_checks = 0, n_pass = 0;
    logic [31:0] t_match[4] = '{32'h277B, 32'h257B, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_mask[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
    logic [3:0] t_sigs[4] = '{4'h4, 4'h1, 4'h0, 4'h0};

    always #5 clk = ~clk;

    pipelined_inst_decoder dut (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_inst(inst),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_sigs(sigs), .io_out_legal(legal), .io_out_idx(idx),
        .io_illegal_cnt(cnt)
`ifdef DECODE_BAD_CAPTURE_EN
        , .io_bad_valid(bad_valid), .io_bad_inst(bad_inst), .io_bad_clr(bad_clr)
`endif
    );

    pipelined_inst_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready2), .io_in_inst(inst),
        .io_out_valid(out_valid2), .io_out_ready(out_ready),
        .io_out_sigs(sigs2), .io_out_legal(legal2), .io_out_idx(idx2),
        .io_illegal_cnt(cnt2)
`ifdef DECODE_BAD_CAPTURE_EN
        , .io_bad_valid(bad_valid2), .io_bad_inst(bad_inst2), .io_bad_clr(bad_clr)
`endif
    );

    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) dut_in <= dut_in + 1;
        if (!reset && out_valid && out_ready) dut_out <= dut_out + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] ref_decode(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            if ((w & t_mask[i]) == t_match[i]) return {t_sigs[i], 1'b1, 2'(i)};
        return 7'd0;
    endfunction

    task automatic check_outputs();
        check("in_ready", in_ready, q.size() != 2);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) check("head", {sigs, legal, idx}, q[0]);
        check("illegal_cnt", cnt, misses > 65535 ? 65535 : misses);
        check("illegal_cnt_sat", cnt2, misses > 3 ? 3 : misses);
`ifdef DECODE_BAD_CAPTURE_EN
        check("bad_valid", bad_valid, exp_bv);
        if (exp_bv) check("bad_inst", bad_inst, exp_bi);
`endif
    endtask

    task automatic cycle(input logic v, input logic [31:0] w, input logic r);
        logic fi, fo;
        logic [6:0] d, tmp;
        @(negedge clk);
        check_outputs();
        in_valid = v;
        inst = w;
        out_ready = r;
        fi = v && q.size() != 2;
        fo = r && q.size() != 0;
        d = ref_decode(w);
        if (fo) tmp = q.pop_front();
        if (fi) begin
            q.push_back(d);
            n_in++;
            if (!d[2]) misses++;
        end
`ifdef DECODE_BAD_CAPTURE_EN
        bad_clr = clr_req;
        if (fi && !d[2] && (!exp_bv || clr_req)) begin
            exp_bv = 1;
            exp_bi = w;
        end else if (clr_req) exp_bv = 0;
`endif
    endtask

    initial begin
        logic [31:0] w;
        repeat (2) @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_head", {sigs, legal, idx}, 0);
        check("reset_cnt", cnt, 0);
        reset = 0;
        // basic decode of each table entry and a miss
        cycle(1, 32'h277B, 1);
        cycle(1, 32'h257B, 1);
        cycle(1, 32'h1234, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        // fill the buffer, stall a third offer, then drain in order
        cycle(1, 32'h277B, 0);
        cycle(1, 32'h257B, 0);
        repeat (3) cycle(1, 32'hDEAD, 0);
        repeat (2) cycle(1, 32'hDEAD, 1);
        repeat (2) cycle(0, 0, 1);
        // push past the small counter's saturation point
        for (int i = 0; i < 5; i++) cycle(1, 32'hF000_0000 | i, 1);
        repeat (2) cycle(0, 0, 1);
`ifdef DECODE_BAD_CAPTURE_EN
        clr_req = 1;
        cycle(0, 0, 1);
        clr_req = 0;
        cycle(1, 32'hAAAA, 1);
        cycle(1, 32'hBBBB, 1);
        cycle(0, 0, 1);
        clr_req = 1;
        cycle(1, 32'hCCCC, 1);
        clr_req = 0;
        repeat (2) cycle(0, 0, 1);
`endif
        // random stream with out_ready toggling every cycle
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: w = 32'h277B;
                1: w = 32'h257B;
                default: w = $urandom;
            endcase
            cycle(1'($urandom_range(0, 1)), w, 1'(i % 2));
        end
        repeat (4) cycle(0, 0, 1);
        check("fire_balance", dut_out, dut_in);
        check("in_fire_count", dut_in, n_in);
        // async reset with data in flight
        cycle(1, 32'h277B, 0);
        cycle(1, 32'h1234, 0);
        @(posedge clk);
        #2 reset = 1;
        in_valid = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_head", {sigs, legal, idx}, 0);
        check("arst_cnt", cnt, 0);
`ifdef DECODE_BAD_CAPTURE_EN
        check("arst_bad", {bad_valid, bad_inst}, 0);
        exp_bv = 0;
`endif
        q.delete();
        misses = 0;
        @(negedge clk);
        reset = 0;
        cycle(0, 0, 1);
        cycle(1, 32'h257B, 1);
        repeat (2) cycle(0, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_inst_decoder.md
Name: pipelined_inst_decoder

Overview:
- Parametrised, pipelined successor to the single-compare list-lookup decoder.
- Matches each accepted instruction word against N mask/match table entries, with first-match priority. Emits the matched entry's control-signal vector, a legal flag and the hit index.
- Sits between instruction fetch and the execute control path, with valid/ready handshakes on both sides.
- Includes a 2-entry output buffer and a saturating illegal-instruction counter.

Parameters:
- INST_W, 32: instruction width.
- SIG_W, 4: control-signal vector width.
- N_ENTRIES, 4: table entries (>=1). IDX_W = max(1, clog2(N_ENTRIES)).
- TABLE_MATCH, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000257B, 32'h0000277B}: packed N_ENTRIES*INST_W; entry 0 in the LSBs.
- TABLE_MASK, {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}: packed N_ENTRIES*INST_W.
- TABLE_SIGS, {4'h0, 4'h0, 4'h1, 4'h4}: packed N_ENTRIES*SIG_W.
- DEFAULT_SIGS, 4'h0: signals driven on a miss.
- CNT_W, 16: illegal-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- io_in_valid  in  1  instruction offered
- io_in_ready  out  1  decoder can accept
- io_in_inst  in  INST_W  instruction word
- io_out_valid  out  1  decoded result available
- io_out_ready  in  1  consumer accepts result
- io_out_sigs  out  SIG_W  decoded control signals
- io_out_legal  out  1  1 = some entry hit
- io_out_idx  out  IDX_W  index of winning entry (0 on miss)
- io_illegal_cnt  out  CNT_W  count of accepted misses
- io_bad_valid / io_bad_inst / io_bad_clr  out 1 / out INST_W / in 1  present only with DECODE_BAD_CAPTURE_EN

Behaviour:
- Hit rule: entry i hits iff (inst & MASK[i]) == MATCH[i].
  - Match bits set outside the mask make an entry unhittable; this is how unused entries are disabled.
  - Lowest index wins.
- Miss: sigs = DEFAULT_SIGS, legal = 0, idx = 0.
- Accept: in_fire = io_in_valid & io_in_ready. The decode is combinational on io_in_inst; its result is written into the buffer on the same edge.
- Buffer: 2-entry FIFO of {sigs, legal, idx}, order preserved.
  - io_in_ready = (count != 2); purely a function of state, no combinational path from io_out_ready.
  - out_fire = io_out_valid & io_out_ready; io_out_valid = (count != 0).
  - io_out_* always present the head entry.
- Latency: a result accepted at edge k is visible at the outputs after edge k (1 cycle) when the buffer was empty.
- Simultaneous events:
  - count 1 with push and pop: count stays 1 and the new entry becomes head.
  - count 0 with push only: count becomes 1.
  - count 2: no push possible; pop takes count to 1.
- Counter: increments on in_fire & miss; saturates at 2^CNT_W-1; never wraps.
- Reset (async, mid-operation included): count = 0, buffered data discarded, io_out_valid = 0, io_out_sigs = 0, io_out_legal = 0, io_out_idx = 0, io_illegal_cnt = 0, io_in_ready = 1 once reset deasserts.
- Outputs are don't-care when io_out_valid = 0, but must equal 0 from reset until the first push.

Optional Feature:
- Macro: DECODE_BAD_CAPTURE_EN.
- With it defined:
  - The first missed instruction accepted while io_bad_valid = 0 is latched into io_bad_inst, and io_bad_valid is set; later misses do not overwrite it.
  - io_bad_clr clears io_bad_valid on the next edge. If clr coincides with a new miss, the new miss is captured (valid stays 1, inst updated).
  - Reset value is 0 for both outputs.
- Without it: the three ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package pipelined_inst_decoder_pkg holds:
  - the decode_result_t typedef {sigs, legal, idx}
  - the default widths
  - a function computing first-match priority over packed tables
- One sub-module: decode_skid_buf, the parametrised 2-entry valid/ready buffer carrying decode_result_t.

Test Plan:
- Reset → io_out_valid = 0, io_in_ready = 1, io_illegal_cnt = 0. Offer inst 0x277B with out_ready = 1 → next cycle sigs = 0x4, legal = 1, idx = 0.
- Offer 0x257B → sigs = 0x1, legal = 1, idx = 1. Offer 0x1234 → sigs = 0x0, legal = 0, idx = 0, illegal_cnt = 1.
- Hold out_ready = 0 and push 0x277B, 0x257B → in_ready = 0 after the second push. A third offer is stalled. Release out_ready → results pop in order 0x4, 0x1, then the third.
- Continuous stream with out_ready toggling every cycle → no loss or duplication; count of out_fire equals count of in_fire.
- Set CNT_W = 2 and push 5 misses → illegal_cnt reaches 3 and stays at 3.
- DECODE_BAD_CAPTURE_EN: misses 0xAAAA then 0xBBBB → bad_inst = 0xAAAA. Assert bad_clr together with miss 0xCCCC → bad_valid = 1, bad_inst = 0xCCCC. Assert reset mid-stream → all state is 0 asynchronously.
